// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared widths and the long-latency queue entry layout for the register file
// writeback scoreboard.
package regfile_wb_scoreboard_pkg;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int EW    = AW + DW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } lq_entry_t;
endpackage

// File: rtl/regfile_wb_scoreboard_sync_fifo.sv
// Small synchronous FIFO with registered storage; the head is read straight from
// the storage array, so a pushed entry is visible at the output the next cycle.
module sync_fifo
  import regfile_wb_scoreboard_pkg::*;
#(
  parameter int WIDTH = EW,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end
endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register file write-port controller: busy-bit scoreboard for long-latency ops,
// issue hazard detection, and arbitration of the single write port.
module regfile_wb_scoreboard
  import regfile_wb_scoreboard_pkg::*;
#(
  parameter int LQ_DEPTH        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_use_rs1,
  input  logic          issue_use_rs2,
  input  logic          issue_long,
  output logic          issue_hazard,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          err_unexpected
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic             err_q, err_d;

  lq_entry_t lq_in, lq_head;
  logic      lq_full, lq_empty, lq_push, lq_pop;
  logic      raw, waw, cap_full, issue_fire, issue_track;
  logic      wb_sel, head_nz, head_busy;

  assign lq_in = '{rd: lu_rd, data: lu_data};

  sync_fifo #(.WIDTH(EW), .DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .pop   (lq_pop),
    .din   (lq_in),
    .dout  (lq_head),
    .full  (lq_full),
    .empty (lq_empty)
  );

  always_comb begin
    raw          = (issue_use_rs1 && busy_q[issue_rs1]) ||
                   (issue_use_rs2 && busy_q[issue_rs2]);
    waw          = (issue_rd != '0) && busy_q[issue_rd];
    cap_full     = issue_long && (issue_rd != '0) &&
                   (outstanding_q == CW'(MAX_OUTSTANDING));
    issue_hazard = rst || (issue_valid && (raw || waw || cap_full));
    issue_fire   = issue_valid && !issue_hazard && !stall;
    issue_track  = issue_fire && issue_long && (issue_rd != '0);

    lu_ready = !rst && !lq_full;
    lq_push  = lu_valid && lu_ready;

    // Pipeline writeback always wins; the queue only drains on idle, unstalled cycles.
    wb_sel    = wb_valid && (wb_rd != '0);
    lq_pop    = !rst && !stall && !wb_sel && !lq_empty;
    head_nz   = (lq_head.rd != '0);
    head_busy = busy_q[lq_head.rd];

    rf_we    = !rst && !stall && (wb_sel || (lq_pop && head_nz));
    rf_waddr = wb_sel ? wb_rd   : lq_head.rd;
    rf_wdata = wb_sel ? wb_data : lq_head.data;

    busy_d        = busy_q;
    err_d         = err_q;
    if (lq_pop && head_busy)             busy_d[lq_head.rd] = 1'b0;
    if (lq_pop && head_nz && !head_busy) err_d = 1'b1;
    if (issue_track)                     busy_d[issue_rd] = 1'b1;
    busy_d[0]     = 1'b0;
    outstanding_d = outstanding_q + CW'(issue_track) - CW'(lq_pop && head_busy);
  end

  assign err_unexpected = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end
endmodule
